pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage 64-bit pipeline.
//  - Drives write-enable and flush/bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//  - Resolves load-use hazards, taken-branch squashes and multi-cycle data-memory waits.
//  - The pipeline registers themselves only load or clear; all sequencing of when they do so lives here.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles spent in MEM_WAIT before abort (>=2)
//  CNT_W        5   width of wait counter; must satisfy 2**CNT_W > MEM_TIMEOUT
// PORTS
//  clk            in   1  pipeline clock
//  reset          in   1  asynchronous, active-low reset
//  IF_ID_rs1      in   5  rs1 of instruction in ID
//  IF_ID_rs2      in   5  rs2 of instruction in ID
//  ID_EX_rd       in   5  rd of instruction in EX
//  ID_EX_MemRead  in   1  instruction in EX is a load
//  branch_taken   in   1  EX resolved a taken branch/jump this cycle
//  mem_req        in   1  instruction in MEM accesses data memory (EX_MEM MemRead|MemWrite)
//  mem_ready      in   1  data memory completes the access this cycle
//  pc_write       out  1  PC load enable
//  if_id_write    out  1  IF/ID load enable
//  if_id_flush    out  1  IF/ID clear to NOP
//  id_ex_flush    out  1  ID/EX clear to bubble (controls zeroed)
//  ex_mem_write   out  1  EX/MEM load enable
//  mem_wb_write   out  1  MEM/WB load enable
//  mem_wb_bubble  out  1  MEM/WB loads bubble (regWrite=0) instead of EX/MEM data
//  mem_err        out  1  one-cycle pulse: memory access aborted by timeout
//  stall_cycles   out 32  [HAZARD_PERF_EN] cycles with pc_write=0
//  flush_count    out 32  [HAZARD_PERF_EN] taken-branch squashes
// BEHAVIOUR
//  - Reset asserted: state=RUN, wait counter=0, mem_err=0, perf counters=0.
//    All *_write=0, both flushes=0, mem_wb_bubble=0 (outputs gated by reset).
//  - States: RUN, MEM_WAIT, ABORT (2-bit encoding, localparams).
//  - Outputs are Mealy (combinational from state + inputs); zero added latency.
//  - RUN, priority high->low:
//    1 mem_req & ~mem_ready: all *_write=0, flushes=0, mem_wb_bubble=0; next MEM_WAIT, counter=1.
//    2 branch_taken: all writes=1, if_id_flush=1, id_ex_flush=1; flush_count++.
//    3 load-use: ID_EX_MemRead & ID_EX_rd!=0 & (ID_EX_rd==IF_ID_rs1 | ID_EX_rd==IF_ID_rs2).
//      pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1, mem_wb_write=1.
//    4 otherwise: all writes=1, flushes=0.
//  - MEM_WAIT: whole pipe frozen (all writes=0); branch_taken/load-use ignored,
//    since EX/ID contents are held and re-evaluated on return to RUN.
//    - mem_ready: behave as RUN rows 2-4 this cycle; next RUN; counter=0.
//    - else if counter==MEM_TIMEOUT-1: next ABORT; counter=0.
//    - else counter++.
//  - ABORT (one cycle): mem_err=1, all writes=1, mem_wb_bubble=1; branch/load-use rules
//    as RUN rows 2-3 apply to upstream controls; next RUN.
//  - mem_ready high in RUN with mem_req: no stall (single-cycle access).
//  - mem_ready without mem_req: ignored.
//  - rd==x0 never causes a load-use stall.
//  - Reset mid-MEM_WAIT: immediate return to RUN, counter cleared, no mem_err.
//  - stall_cycles/flush_count wrap at 2**32.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//   - stall_cycles increments every cycle pc_write==0 (reset deasserted).
//   - flush_count increments per branch squash.
//  HAZARD_PERF_EN undefined:
//   - both ports are absent; no counter flops.
// STRUCTURE
//  pipe_ctrl_pkg holds:
//   - state encoding localparams (ST_RUN, ST_MEM_WAIT, ST_ABORT);
//   - REG_X0 constant;
//   - the load-use compare as a function.
//  One sub-module: hazard_perf_cnt.
//   - 32-bit saturating-free event counter, instantiated twice under HAZARD_PERF_EN.
// TESTING
//  1 Reset low 3 cycles, then high.
//    - While low: all writes=0.
//    - First cycle high, no hazards: all writes=1, flushes=0.
//  2 ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs2=5:
//    - one cycle pc_write=0, if_id_write=0, id_ex_flush=1.
//    - MemRead=0 next cycle -> writes=1.
//  3 Load-use with ID_EX_rd=0, rs1=0: no stall.
//  4 mem_req=1, mem_ready=0 for 4 cycles, then 1:
//    - 4 frozen cycles; release cycle all writes=1; stall_cycles=4 (PERF_EN).
//  5 mem_req=1, mem_ready stuck 0, MEM_TIMEOUT=16:
//    - 16 frozen cycles;
//    - then ABORT cycle with mem_err=1, mem_wb_bubble=1;
//    - then RUN.
//  6 branch_taken=1 while in MEM_WAIT, mem_ready after 2 cycles:
//    - no flush during wait;
//    - release cycle if_id_flush=id_ex_flush=1, flush_count=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the controller state encoding, the x0 register constant, the
// control-bundle payload type, the load-use compare and the upstream
// (branch / load-use / normal) control selection used by every state
// that lets the pipe advance.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned PERF_W = 32;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ABORT    = 2'd2;

  localparam logic [REG_W-1:0] REG_X0 = REG_W'(0);

  typedef enum logic [1:0] {
    S_RUN      = ST_RUN,
    S_MEM_WAIT = ST_MEM_WAIT,
    S_ABORT    = ST_ABORT
  } state_e;

  // One cycle's worth of pipeline-register controls.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_write;
    logic mem_wb_bubble;
    logic mem_err;
  } pipe_ctrl_t;

  // Load in EX writing a register that the instruction in ID reads; x0 never counts.
  function automatic logic load_use_hazard(input logic             mem_read,
                                           input logic [REG_W-1:0] rd,
                                           input logic [REG_W-1:0] rs1,
                                           input logic [REG_W-1:0] rs2);
    return mem_read && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
  endfunction

  // Controls for an advancing pipe: a taken branch squashes IF/ID and ID/EX,
  // otherwise a load-use holds PC and IF/ID and injects a bubble into ID/EX.
  function automatic pipe_ctrl_t upstream_ctrl(input logic branch, input logic hazard);
    pipe_ctrl_t c;
    c              = '0;
    c.ex_mem_write = 1'b1;
    c.mem_wb_write = 1'b1;
    if (branch) begin
      c.pc_write    = 1'b1;
      c.if_id_write = 1'b1;
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (hazard) begin
      c.id_ex_flush = 1'b1;
    end else begin
      c.pc_write    = 1'b1;
      c.if_id_write = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running 32-bit event counter, wraps at 2**32.
// Ports: clk, reset (async active-low), inc (count this cycle), count.
module hazard_perf_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + PERF_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: generates PC / IF/ID /
// ID/EX / EX/MEM / MEM/WB load and clear controls for load-use hazards,
// taken-branch squashes and multi-cycle data-memory accesses (with abort
// after MEM_TIMEOUT frozen cycles).
// Ports: clk, reset (async active-low); IF_ID_rs1/rs2, ID_EX_rd,
// ID_EX_MemRead, branch_taken, mem_req, mem_ready in; Mealy control
// outputs pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write,
// mem_wb_write, mem_wb_bubble, mem_err.
// Optional macro HAZARD_PERF_EN adds stall_cycles and flush_count counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] IF_ID_rs1,
  input  logic [REG_W-1:0] IF_ID_rs2,
  input  logic [REG_W-1:0] ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             mem_wb_bubble,
  output logic             mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  pipe_ctrl_t       ctrl;

  assign load_use = load_use_hazard(ID_EX_MemRead, ID_EX_rd, IF_ID_rs1, IF_ID_rs2);

  // State and wait-counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Mealy controls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = '0;
    case (state_q)
      S_RUN: begin
        // A memory miss outranks everything: freeze the whole pipe.
        if (mem_req && !mem_ready) begin
          state_d = S_MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          ctrl = upstream_ctrl(branch_taken, load_use);
        end
      end
      S_MEM_WAIT: begin
        // Held EX/ID contents are only acted on in the release cycle.
        if (mem_ready) begin
          ctrl    = upstream_ctrl(branch_taken, load_use);
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d = S_ABORT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ABORT: begin
        // Retire the aborted access as a bubble while upstream advances.
        ctrl               = upstream_ctrl(branch_taken, load_use);
        ctrl.mem_wb_bubble = 1'b1;
        ctrl.mem_err       = 1'b1;
        state_d            = S_RUN;
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
    if (!reset) begin
      ctrl = '0;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_write  = ctrl.ex_mem_write;
  assign mem_wb_write  = ctrl.mem_wb_write;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign mem_err       = ctrl.mem_err;

`ifdef HAZARD_PERF_EN
  // if_id_flush is asserted only for a taken-branch squash.
  hazard_perf_cnt u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!ctrl.pc_write),
    .count (stall_cycles)
  );

  hazard_perf_cnt u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl.if_id_flush),
    .count (flush_count)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MEM_TIMEOUT = 16;

  logic       clk;
  logic       reset;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
  logic       ID_EX_MemRead, branch_taken, mem_req, mem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic       ex_mem_write, mem_wb_write, mem_wb_bubble, mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .IF_ID_rs1     (IF_ID_rs1),
    .IF_ID_rs2     (IF_ID_rs2),
    .ID_EX_rd      (ID_EX_rd),
    .ID_EX_MemRead (ID_EX_MemRead),
    .branch_taken  (branch_taken),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_write  (ex_mem_write),
    .mem_wb_write  (mem_wb_write),
    .mem_wb_bubble (mem_wb_bubble),
    .mem_err       (mem_err)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected controls, bit order:
  // pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write, mem_wb_bubble, mem_err
  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] st;
    logic [31:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: how many consecutive frozen cycles the current access has
  // cost (0 = no access outstanding), and whether the next cycle is the abort.
  int          frozen_run = 0;
  bit          abort_next = 1'b0;
  int unsigned m_stall    = 0;
  int unsigned m_flush    = 0;

  task automatic model_step(input bit rst, input bit req, input bit rdy, input bit br,
                            input bit ld, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2);
    exp_t       x;
    logic [7:0] up;
    logic [7:0] e;
    bit         lu;
    bit         advanced;
    if (!rst) begin
      frozen_run = 0;
      abort_next = 1'b0;
      m_stall    = 0;
      m_flush    = 0;
      x.ctrl = 8'h00; x.st = 32'd0; x.fc = 32'd0;
      sb_q.push_back(x);
      return;
    end
    lu = ld && (rd != 5'd0) && (rd == rs1 || rd == rs2);
    if (br)      up = 8'b1111_1100;
    else if (lu) up = 8'b0001_1100;
    else         up = 8'b1100_1100;
    advanced = 1'b0;
    e = 8'h00;
    if (abort_next) begin
      e = up | 8'b0000_0011;
      abort_next = 1'b0;
      advanced = 1'b1;
    end else if (frozen_run > 0) begin
      if (rdy) begin
        e = up;
        frozen_run = 0;
        advanced = 1'b1;
      end else begin
        frozen_run++;
        if (frozen_run == int'(MEM_TIMEOUT)) begin
          frozen_run = 0;
          abort_next = 1'b1;
        end
      end
    end else if (req && !rdy) begin
      frozen_run = 1;
    end else begin
      e = up;
      advanced = 1'b1;
    end
    x.ctrl = e;
    x.st   = 32'(m_stall);
    x.fc   = 32'(m_flush);
    sb_q.push_back(x);
    if (!e[7]) m_stall++;
    if (advanced && br) m_flush++;
  endtask

  task automatic drive(input bit rst, input bit req, input bit rdy, input bit br,
                       input bit ld, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    @(posedge clk);
    #2;
    reset         = rst;
    mem_req       = req;
    mem_ready     = rdy;
    branch_taken  = br;
    ID_EX_MemRead = ld;
    ID_EX_rd      = rd;
    IF_ID_rs1     = rs1;
    IF_ID_rs2     = rs2;
    model_step(rst, req, rdy, br, ld, rd, rs1, rs2);
  endtask

  // Monitor: one set of Mealy outputs is presented per cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t       x;
    logic [7:0] got;
    if (sb_q.size() > 0) begin
      x   = sb_q.pop_front();
      got = {pc_write, if_id_write, if_id_flush, id_ex_flush,
             ex_mem_write, mem_wb_write, mem_wb_bubble, mem_err};
      checks++;
      if (got !== x.ctrl) begin
        errors++;
        $display("FAIL ctrl @%0t: got %b expected %b", $time, got, x.ctrl);
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (stall_cycles !== x.st) begin
        errors++;
        $display("FAIL stall_cycles @%0t: got %0d expected %0d", $time, stall_cycles, x.st);
      end
      checks++;
      if (flush_count !== x.fc) begin
        errors++;
        $display("FAIL flush_count @%0t: got %0d expected %0d", $time, flush_count, x.fc);
      end
`endif
    end
  end

  initial begin
    int stuck;
    reset = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    ID_EX_MemRead = 1'b0; ID_EX_rd = 5'd0; IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0;

    // Reset held three cycles, then a clean cycle.
    repeat (3) drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // Load-use on rs2, then cleared.
    drive(1, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5);
    drive(1, 0, 0, 0, 0, 5'd5, 5'd1, 5'd5);
    // Load to x0 never stalls.
    drive(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd3);
    // Four-cycle memory wait then release.
    repeat (4) drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // Single-cycle access and stray mem_ready.
    drive(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    // Timeout: 16 frozen cycles, abort cycle, back to RUN.
    repeat (16) drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // Branch held during a wait: squashed only on release.
    drive(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // Reset in the middle of a wait.
    drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // Timeout with load-use and branch present on the abort cycle.
    repeat (16) drive(1, 1, 0, 0, 1, 5'd2, 5'd2, 5'd0);
    drive(1, 0, 0, 0, 1, 5'd2, 5'd2, 5'd0);
    repeat (16) drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(1, 0, 0, 1, 1, 5'd2, 5'd2, 5'd0);

    // Randomized traffic with occasional stuck memory.
    stuck = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rst, req, rdy, br, ld;
      rst = ($urandom_range(0, 199) != 0);
      req = ($urandom_range(0, 99) < 30);
      if (stuck == 0 && $urandom_range(0, 59) == 0) stuck = 20;
      if (stuck > 0) begin
        rdy = 1'b0;
        req = 1'b1;
        stuck--;
      end else begin
        rdy = ($urandom_range(0, 99) < 40);
      end
      br = ($urandom_range(0, 99) < 15);
      ld = ($urandom_range(0, 1) == 1);
      drive(rst, req, rdy, br, ld, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    #6;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
